// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, parity modes and a parity helper.
// Used by both the transmitter and the companion receiver.
package uart_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   // Parity bit for a zero-extended payload: odd mode makes the total number
   // of ones (data + parity) odd, even mode makes it even.
   function automatic logic parityBit(input logic [8:0] data, input int mode);
      return (mode == PAR_ODD) ? ~^data : ^data;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count. A push while full and a
// pop while empty are ignored. A word pushed into an empty FIFO becomes
// visible at the head only on the following cycle.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic [WIDTH-1:0]         i_data,
   output logic [WIDTH-1:0]         o_data,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wrPtr;
   logic [AW-1:0]    r_rdPtr;
   logic [AW:0]      r_count;
   logic             w_pushOk;
   logic             w_popOk;

   assign w_pushOk = i_push && !o_full;
   assign w_popOk  = i_pop && !o_empty;

   // Storage array; contents need no reset because the count guards reads.
   always_ff @(posedge clk) begin
      if (w_pushOk) begin
         r_mem[r_wrPtr] <= i_data;
      end
   end

   // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_pushOk) begin
            r_wrPtr <= r_wrPtr + AW'(1);
         end
         if (w_popOk) begin
            r_rdPtr <= r_rdPtr + AW'(1);
         end
         if (w_pushOk && !w_popOk) begin
            r_count <= r_count + (AW+1)'(1);
         end else if (w_popOk && !w_pushOk) begin
            r_count <= r_count - (AW+1)'(1);
         end
      end
   end

   assign o_data  = r_mem[r_rdPtr];
   assign o_full  = (r_count == (AW+1)'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter with an input FIFO. Frames are start bit,
// LSB-first payload, optional parity and one or two stop bits. A queued word
// is popped in the final stop-bit cycle so consecutive frames have no gap.
module uart_tx_frame
   import uart_pkg::*;
#(
   parameter int CLK_PER_BIT = 87,
   parameter int DATA_BITS   = 8,
   parameter int PARITY      = 0,
   parameter int STOP_BITS   = 1,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          i_valid,
   input  logic [DATA_BITS-1:0]          i_data,
   output logic                          o_ready,
   output logic                          o_tx,
   output logic                          o_busy,
   output logic                          o_done,
   output logic [2:0]                    o_state,
   output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

   localparam int CW = $clog2(CLK_PER_BIT);
   localparam int BW = $clog2(DATA_BITS);

   logic [2:0]           r_state;
   logic [CW-1:0]        r_clkCnt;
   logic [BW-1:0]        r_bitCnt;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_parity;
   logic                 r_tx;

   logic [DATA_BITS-1:0] w_fifoData;
   logic                 w_full;
   logic                 w_empty;
   logic                 w_wrap;
   logic                 w_lastStop;
   logic                 w_pop;

   sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (i_valid),
      .i_pop   (w_pop),
      .i_data  (i_data),
      .o_data  (w_fifoData),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (o_fifo_count)
   );

   assign w_wrap     = (r_clkCnt == CW'(CLK_PER_BIT - 1));
   assign w_lastStop = (r_state == ST_STOP) && w_wrap && (r_bitCnt == BW'(STOP_BITS - 1));
   assign w_pop      = !w_empty && ((r_state == ST_IDLE) || w_lastStop);

   // Frame sequencer: bit-period timing, payload shifting and line driving.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_clkCnt <= '0;
         r_bitCnt <= '0;
         r_shift  <= '0;
         r_parity <= 1'b0;
         r_tx     <= 1'b1;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_tx <= 1'b1;
               if (w_pop) begin
                  r_shift  <= w_fifoData;
                  r_parity <= parityBit(9'(w_fifoData), PARITY);
                  r_clkCnt <= '0;
                  r_bitCnt <= '0;
                  r_state  <= ST_START;
                  r_tx     <= 1'b0;
               end
            end
            ST_START: begin
               if (w_wrap) begin
                  r_clkCnt <= '0;
                  r_state  <= ST_DATA;
                  r_tx     <= r_shift[0];
               end else begin
                  r_clkCnt <= r_clkCnt + CW'(1);
               end
            end
            ST_DATA: begin
               if (w_wrap) begin
                  r_clkCnt <= '0;
                  r_shift  <= r_shift >> 1;
                  if (r_bitCnt == BW'(DATA_BITS - 1)) begin
                     r_bitCnt <= '0;
                     if (PARITY != PAR_NONE) begin
                        r_state <= ST_PARITY;
                        r_tx    <= r_parity;
                     end else begin
                        r_state <= ST_STOP;
                        r_tx    <= 1'b1;
                     end
                  end else begin
                     r_bitCnt <= r_bitCnt + BW'(1);
                     r_tx     <= r_shift[1];
                  end
               end else begin
                  r_clkCnt <= r_clkCnt + CW'(1);
               end
            end
            ST_PARITY: begin
               if (w_wrap) begin
                  r_clkCnt <= '0;
                  r_state  <= ST_STOP;
                  r_tx     <= 1'b1;
               end else begin
                  r_clkCnt <= r_clkCnt + CW'(1);
               end
            end
            ST_STOP: begin
               if (w_wrap) begin
                  r_clkCnt <= '0;
                  if (r_bitCnt == BW'(STOP_BITS - 1)) begin
                     r_bitCnt <= '0;
                     if (w_pop) begin
                        r_shift  <= w_fifoData;
                        r_parity <= parityBit(9'(w_fifoData), PARITY);
                        r_state  <= ST_START;
                        r_tx     <= 1'b0;
                     end else begin
                        r_state <= ST_IDLE;
                        r_tx    <= 1'b1;
                     end
                  end else begin
                     r_bitCnt <= r_bitCnt + BW'(1);
                  end
               end else begin
                  r_clkCnt <= r_clkCnt + CW'(1);
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_tx    <= 1'b1;
            end
         endcase
      end
   end

   assign o_ready = !w_full;
   assign o_tx    = r_tx;
   assign o_busy  = (r_state != ST_IDLE);
   assign o_done  = w_lastStop;
   assign o_state = r_state;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame (7 data bits, even parity, 2 stop bits).
// A frame-level reference model predicts the line, state and FIFO occupancy
// every cycle; directed sequences pin the model with hand-computed values.
module tb_uart_tx_frame;

   localparam int CPB   = 4;
   localparam int DB    = 7;
   localparam int PAR   = 2;
   localparam int SB    = 2;
   localparam int DEPTH = 4;
   localparam int NBITS = 1 + DB + ((PAR != 0) ? 1 : 0) + SB;
   localparam int FRAME = NBITS * CPB;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          i_valid = 1'b0;
   logic [DB-1:0] i_data = '0;
   logic          o_ready;
   logic          o_tx;
   logic          o_busy;
   logic          o_done;
   logic [2:0]    o_state;
   logic [2:0]    o_fifo_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   uart_tx_frame #(
      .CLK_PER_BIT (CPB),
      .DATA_BITS   (DB),
      .PARITY      (PAR),
      .STOP_BITS   (SB),
      .FIFO_DEPTH  (DEPTH)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .i_valid      (i_valid),
      .i_data       (i_data),
      .o_ready      (o_ready),
      .o_tx         (o_tx),
      .o_busy       (o_busy),
      .o_done       (o_done),
      .o_state      (o_state),
      .o_fifo_count (o_fifo_count)
   );

   // One comparison: counts it and reports a FAIL line on mismatch.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive inputs for the current cycle and advance to just after the next edge.
   task automatic applyStimulus(input logic v, input logic [DB-1:0] d);
      i_valid = v;
      i_data  = d;
      @(posedge clk);
      #1;
   endtask

   // ---------------- reference model ----------------
   logic [DB-1:0] mq[$];
   int            pos = -1;
   logic          frameBits [FRAME];
   int            frameState[FRAME];
   bit            checkEn = 0;
   int            sz;
   bit            popNow;

   // Expand one word into the per-cycle line value and state of its frame.
   function automatic void buildFrame(input logic [DB-1:0] w);
      logic b;
      int   s;
      for (int i = 0; i < NBITS; i++) begin
         if (i == 0) begin
            b = 1'b0; s = 1;
         end else if (i <= DB) begin
            b = w[i-1]; s = 2;
         end else if (PAR != 0 && i == DB + 1) begin
            b = (PAR == 2) ? logic'($countones(w) % 2 == 1) : logic'($countones(w) % 2 == 0);
            s = 3;
         end else begin
            b = 1'b1; s = 4;
         end
         for (int k = 0; k < CPB; k++) begin
            frameBits[i*CPB+k]  = b;
            frameState[i*CPB+k] = s;
         end
      end
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         mq.delete();
         pos     = -1;
         checkEn = 1;
      end else begin
         sz     = mq.size();
         popNow = ((pos < 0) || (pos == FRAME - 1)) && (sz > 0);
         if (pos == FRAME - 1) pos = -1;
         else if (pos >= 0) pos++;
         if (popNow) begin
            buildFrame(mq.pop_front());
            pos = 0;
         end
         if (i_valid && sz < DEPTH) mq.push_back(i_data);
      end
   end

   always @(negedge clk) begin
      if (checkEn) begin
         checkOutput("tx",    32'(o_tx),         (pos < 0) ? 32'd1 : 32'(frameBits[pos]));
         checkOutput("state", 32'(o_state),      (pos < 0) ? 32'd0 : 32'(frameState[pos]));
         checkOutput("busy",  32'(o_busy),       32'(pos >= 0));
         checkOutput("done",  32'(o_done),       32'(pos == FRAME - 1));
         checkOutput("count", 32'(o_fifo_count), 32'(mq.size()));
         checkOutput("ready", 32'(o_ready),      32'(mq.size() < DEPTH));
      end
   end

   // ---------------- directed + random stimulus ----------------
   logic [NBITS-1:0] capBits;
   int               doneAt;
   logic [NBITS-1:0] exp55;
   int               doneCnt;
   int               gapCnt;
   int               lowCnt;

   // Send one word from idle, check the fall timing and capture mid-bit samples.
   task automatic captureFrame(input logic [DB-1:0] d);
      logic line[FRAME];
      applyStimulus(1'b1, d);
      checkOutput("cap_count1", 32'(o_fifo_count), 32'd1);
      checkOutput("cap_txIdle", 32'(o_tx), 32'd1);
      applyStimulus(1'b0, '0);
      checkOutput("cap_fall", 32'(o_tx), 32'd0);
      checkOutput("cap_busy", 32'(o_busy), 32'd1);
      doneAt = -1;
      for (int i = 0; i < FRAME; i++) begin
         line[i] = o_tx;
         if (o_done) doneAt = i;
         applyStimulus(1'b0, '0);
      end
      for (int b = 0; b < NBITS; b++) capBits[b] = line[b*CPB+1];
      checkOutput("cap_doneAt", 32'(doneAt), 32'(FRAME - 1));
      checkOutput("cap_endTx", 32'(o_tx), 32'd1);
      checkOutput("cap_endBusy", 32'(o_busy), 32'd0);
   endtask

   initial begin
      applyStimulus(1'b0, '0);
      applyStimulus(1'b0, '0);
      checkOutput("rst_tx", 32'(o_tx), 32'd1);
      checkOutput("rst_busy", 32'(o_busy), 32'd0);
      checkOutput("rst_done", 32'(o_done), 32'd0);
      checkOutput("rst_state", 32'(o_state), 32'd0);
      checkOutput("rst_count", 32'(o_fifo_count), 32'd0);
      checkOutput("rst_ready", 32'(o_ready), 32'd1);
      rst = 1'b0;
      applyStimulus(1'b0, '0);

      // 0x55, 7 bits LSB first 1010101, even parity 0, two stop bits.
      exp55 = 11'b11010101010;
      captureFrame(7'h55);
      checkOutput("frame55", 32'(capBits), 32'(exp55));

      // 0x7F has seven ones, so even parity bit is 1.
      captureFrame(7'h7F);
      checkOutput("par7F", 32'(capBits[DB+1]), 32'd1);
      checkOutput("start7F", 32'(capBits[0]), 32'd0);

      // Six consecutive writes from idle: five accepted, FIFO then full.
      for (int k = 0; k < 6; k++) applyStimulus(1'b1, DB'($urandom));
      i_valid = 1'b0;
      checkOutput("burst_count", 32'(o_fifo_count), 32'd4);
      checkOutput("burst_ready", 32'(o_ready), 32'd0);
      doneCnt = 0;
      gapCnt  = 0;
      for (int c = 0; c < 5 * FRAME + 20 && doneCnt < 5; c++) begin
         if (o_done) doneCnt++;
         if (!o_busy) gapCnt++;
         applyStimulus(1'b0, '0);
      end
      checkOutput("burst_dones", 32'(doneCnt), 32'd5);
      checkOutput("burst_gaps", 32'(gapCnt), 32'd0);
      for (int c = 0; c < 4; c++) applyStimulus(1'b0, '0);

      // Reset in the middle of the data bits with two words still queued.
      for (int k = 0; k < 3; k++) applyStimulus(1'b1, DB'($urandom));
      i_valid = 1'b0;
      for (int c = 0; c < 40 && o_state != 3'd2; c++) applyStimulus(1'b0, '0);
      checkOutput("mid_state", 32'(o_state), 32'd2);
      checkOutput("mid_count", 32'(o_fifo_count), 32'd2);
      rst = 1'b1;
      applyStimulus(1'b0, '0);
      rst = 1'b0;
      checkOutput("mrst_tx", 32'(o_tx), 32'd1);
      checkOutput("mrst_state", 32'(o_state), 32'd0);
      checkOutput("mrst_count", 32'(o_fifo_count), 32'd0);
      checkOutput("mrst_done", 32'(o_done), 32'd0);
      lowCnt = 0;
      for (int c = 0; c < 60; c++) begin
         if (!o_tx || o_done) lowCnt++;
         applyStimulus(1'b0, '0);
      end
      checkOutput("mrst_quiet", 32'(lowCnt), 32'd0);

      // Randomised traffic with occasional resets, checked by the model.
      for (int c = 0; c < 1500; c++) begin
         rst = ($urandom_range(0, 499) == 0);
         applyStimulus($urandom_range(0, 3) == 0, DB'($urandom));
      end
      rst = 1'b0;
      for (int c = 0; c < 6 * FRAME; c++) applyStimulus(1'b0, '0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
